// File: rtl/riscv_pkg.sv
// Shared types and constants for the core front end: PC-stage FSM states,
// next-PC source encoding and default vectors.
package riscv_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JAL    = 2'd2,
    PC_JALR   = 2'd3
  } next_pc_sel_e;

  localparam logic [31:0] PC_RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_TRAP_VECTOR_DEFAULT  = 32'h0000_0100;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: priority jalr > jump > branch > sequential,
// target adders, and misaligned-target detection for non-sequential targets.
module pc_next_sel
  import riscv_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  output logic [31:0] target,
  output logic        misaligned
);

  next_pc_sel_e sel;
  logic [31:0]  pc_rel;
  logic [31:0]  reg_rel;

  assign pc_rel  = pc + imm;
  assign reg_rel = (rs1_data + imm) & ~32'h1;

  always_comb begin
    sel = PC_SEQ;
    if (jalr)              sel = PC_JALR;
    else if (jump)         sel = PC_JAL;
    else if (branch_taken) sel = PC_BRANCH;
  end

  always_comb begin
    target = pc + 32'd4;
    case (sel)
      PC_JALR:           target = reg_rel;
      PC_JAL, PC_BRANCH: target = pc_rel;
      default:           target = pc + 32'd4;
    endcase
  end

  // Sequential targets are always aligned; only redirects can fault (no C extension).
  assign misaligned = (sel != PC_SEQ) && target[1];

endmodule

// File: rtl/pc_control.sv
// PC stage: BOOT/RUN/TRAP FSM, registered PC, trap capture and retired-instruction
// counter. Handshake: an instruction retires on a clock edge where pc_valid && pc_ready.
module pc_control
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR_DEFAULT,
  parameter logic [31:0] TRAP_VECTOR  = PC_TRAP_VECTOR_DEFAULT,
  parameter logic [63:0] INSTRET_INIT = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        pc_ready,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic [31:0] pc_plus4,
  output logic        trap,
  output logic [31:0] trap_pc,
  output logic [63:0] instret,
  output pc_state_e   dbg_state
);

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [63:0] instret_q, instret_d;
  logic        pc_valid_q, trap_q;
  logic [31:0] target;
  logic        misaligned;
  logic        fire;

  pc_next_sel u_next_sel (
    .pc           (pc_q),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jalr         (jalr),
    .imm          (imm),
    .rs1_data     (rs1_data),
    .target       (target),
    .misaligned   (misaligned)
  );

  assign fire = pc_valid_q && pc_ready;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    trap_pc_d = trap_pc_q;
    instret_d = instret_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (fire) begin
          if (misaligned) begin
            // Faulting instruction does not retire; pc stays on it until the vector load.
            state_d   = TRAP;
            trap_pc_d = pc_q;
          end else begin
            pc_d      = target;
            instret_d = instret_q + 64'd1;
          end
        end
      end
      TRAP: begin
        pc_d    = TRAP_VECTOR;
        state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      trap_pc_q  <= 32'd0;
      instret_q  <= INSTRET_INIT;
      pc_valid_q <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      trap_pc_q  <= trap_pc_d;
      instret_q  <= instret_d;
      pc_valid_q <= (state_d == RUN);
      trap_q     <= (state_d == TRAP);
    end
  end

  assign pc        = pc_q;
  assign pc_valid  = pc_valid_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign trap      = trap_q;
  assign trap_pc   = trap_pc_q;
  assign instret   = instret_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_control.sv
// Directed bench for pc_control: boot sequence, target priority, misaligned trap,
// stall, address/counter wrap and asynchronous reset during a trap cycle.
module tb_pc_control;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_taken, jump, jalr, pc_ready;
  logic [31:0] imm, rs1_data;

  logic [31:0] pc, pc_plus4, trap_pc;
  logic        pc_valid, trap;
  logic [63:0] instret;
  pc_state_e   dbg_state;

  logic [31:0] pc_w, pc_plus4_w, trap_pc_w;
  logic        pc_valid_w, trap_w;
  logic [63:0] instret_w;
  pc_state_e   dbg_state_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_control dut (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .jump(jump), .jalr(jalr),
    .imm(imm), .rs1_data(rs1_data), .pc_ready(pc_ready),
    .pc(pc), .pc_valid(pc_valid), .pc_plus4(pc_plus4), .trap(trap),
    .trap_pc(trap_pc), .instret(instret), .dbg_state(dbg_state)
  );

  // Second instance starts its counter at the top value to exercise the 64-bit wrap.
  pc_control #(.INSTRET_INIT(64'hFFFF_FFFF_FFFF_FFFF)) dut_wrap (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .jump(jump), .jalr(jalr),
    .imm(imm), .rs1_data(rs1_data), .pc_ready(pc_ready),
    .pc(pc_w), .pc_valid(pc_valid_w), .pc_plus4(pc_plus4_w), .trap(trap_w),
    .trap_pc(trap_pc_w), .instret(instret_w), .dbg_state(dbg_state_w)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctrl(input logic b, input logic j, input logic jr,
                      input logic [31:0] i, input logic [31:0] r);
    branch_taken = b;
    jump         = j;
    jalr         = jr;
    imm          = i;
    rs1_data     = r;
  endtask

  initial begin
    rst = 1'b1;
    pc_ready = 1'b1;
    ctrl(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", pc_valid, 1'b0);
    chk("rst_trap", trap, 1'b0);
    chk("rst_trap_pc", trap_pc, 32'h0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_state", dbg_state, BOOT);

    rst = 1'b0;
    chk("boot_valid", pc_valid, 1'b0);
    step();
    chk("run0_valid", pc_valid, 1'b1);
    chk("run0_pc", pc, 32'h0);
    chk("run0_instret", instret, 64'd0);
    chk("wrap_init", instret_w, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    chk("seq1_pc", pc, 32'h4);
    chk("seq1_instret", instret, 64'd1);
    chk("instret_wrap", instret_w, 64'd0);
    step();
    chk("seq2_pc", pc, 32'h8);
    chk("seq2_instret", instret, 64'd2);
    chk("seq2_plus4", pc_plus4, 32'hC);
    chk("wrap_after", instret_w, 64'd1);

    ctrl(1'b0, 1'b0, 1'b1, 32'd0, 32'h40);
    step();
    chk("jalr_pc40", pc, 32'h40);
    chk("jalr_instret", instret, 64'd3);

    ctrl(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'd0);
    step();
    chk("branch_neg_pc", pc, 32'h38);
    chk("branch_neg_plus4", pc_plus4, 32'h3C);
    chk("branch_instret", instret, 64'd4);

    ctrl(1'b1, 1'b1, 1'b1, 32'd0, 32'h1001);
    step();
    chk("prio_jalr_pc", pc, 32'h1000);
    chk("prio_trap", trap, 1'b0);
    chk("prio_instret", instret, 64'd5);

    ctrl(1'b0, 1'b0, 1'b1, 32'd0, 32'h80);
    step();
    chk("jalr_pc80", pc, 32'h80);

    ctrl(1'b0, 1'b1, 1'b0, 32'h6, 32'd0);
    step();
    chk("mis_trap", trap, 1'b1);
    chk("mis_valid", pc_valid, 1'b0);
    chk("mis_trap_pc", trap_pc, 32'h80);
    chk("mis_instret", instret, 64'd6);
    chk("mis_state", dbg_state, TRAP);
    ctrl(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    chk("vec_pc", pc, 32'h100);
    chk("vec_valid", pc_valid, 1'b1);
    chk("vec_trap_low", trap, 1'b0);
    chk("vec_instret", instret, 64'd6);
    chk("vec_trap_pc_held", trap_pc, 32'h80);

    pc_ready = 1'b0;
    ctrl(1'b1, 1'b0, 1'b0, 32'h20, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc, 32'h100);
      chk("stall_instret", instret, 64'd6);
    end
    pc_ready = 1'b1;
    step();
    chk("unstall_pc", pc, 32'h120);
    chk("unstall_instret", instret, 64'd7);

    ctrl(1'b0, 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFC);
    step();
    chk("top_pc", pc, 32'hFFFF_FFFC);
    chk("top_plus4", pc_plus4, 32'h0);
    ctrl(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    step();
    chk("addr_wrap_pc", pc, 32'h0);
    chk("addr_wrap_trap", trap, 1'b0);
    chk("addr_wrap_instret", instret, 64'd9);
    step();
    chk("post_wrap_pc", pc, 32'h4);

    ctrl(1'b0, 1'b1, 1'b0, 32'h6, 32'd0);
    step();
    chk("trap2_trap", trap, 1'b1);
    chk("trap2_trap_pc", trap_pc, 32'h4);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_trap", trap, 1'b0);
    chk("arst_pc", pc, 32'h0);
    chk("arst_valid", pc_valid, 1'b0);
    chk("arst_trap_pc", trap_pc, 32'h0);
    chk("arst_instret", instret, 64'd0);
    chk("arst_state", dbg_state, BOOT);
    step();
    rst = 1'b0;
    ctrl(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("reboot_valid", pc_valid, 1'b0);
    step();
    chk("reboot_run_valid", pc_valid, 1'b1);
    chk("reboot_pc", pc, 32'h0);
    chk("reboot_trap", trap, 1'b0);
    step();
    chk("reboot_seq_pc", pc, 32'h4);
    chk("reboot_instret", instret, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
